// File: rtl/connector_pkg.sv
// Shared lane identifiers and round-robin helper for the connector write-merge slice.
package connector_pkg;

  localparam int NLANES = 3;
  localparam int LW     = $clog2(NLANES);

  typedef logic [LW-1:0] lane_id_t;

  function automatic lane_id_t rr_next(input lane_id_t l);
    return (l == lane_id_t'(NLANES - 1)) ? '0 : lane_id_t'(l + 1'b1);
  endfunction

endpackage

// File: rtl/connector_wr_fifo.sv
// Per-lane write FIFO: push is ignored when full, pop is ignored when empty.
module connector_wr_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a push.
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/connector_wr_merge.sv
// Merges per-lane write streams into one valid/ready stream, round-robin across
// non-empty lane FIFOs, with lane tagging and sticky per-lane overflow flags.
module connector_wr_merge #(
  parameter int NLANES = 3,
  parameter int DW     = 8,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NLANES-1:0]           wen,
  input  logic [NLANES*DW-1:0]        data,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [DW-1:0]               out_data,
  output logic [$clog2(NLANES)-1:0]   out_lane,
  input  logic                        clear_ovf,
  output logic [NLANES-1:0]           overflow,
  output logic [NLANES-1:0]           fifo_empty
);

  import connector_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [NLANES-1:0] empty;
  logic [NLANES-1:0] full;
  logic [NLANES-1:0] pop;
  logic [DW-1:0]     pop_data [NLANES];
  logic [CW-1:0]     count    [NLANES];
  logic [NLANES-1:0] ovf_next;
  lane_id_t          rr;
  lane_id_t          grant;
  lane_id_t          li;
  logic              found;
  logic [DW-1:0]     grant_data;
  logic              load_en;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    connector_wr_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (wen[i]),
      .push_data (data[i*DW +: DW]),
      .pop       (pop[i]),
      .pop_data  (pop_data[i]),
      .empty     (empty[i]),
      .full      (full[i]),
      .count     (count[i])
    );
    assign fifo_empty[i] = (count[i] == '0);
  end

  assign load_en = !out_valid || out_ready;

  // Scan lanes starting at rr; the first non-empty one wins.
  always_comb begin
    found      = 1'b0;
    grant      = '0;
    grant_data = '0;
    li         = '0;
    for (int unsigned k = 0; k < NLANES; k++) begin
      li = lane_id_t'((32'(rr) + k) % NLANES);
      if (!found && !empty[li]) begin
        found      = 1'b1;
        grant      = li;
        grant_data = pop_data[li];
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load_en && found) pop[grant] = 1'b1;
  end

  // A fresh overflow on the clearing cycle survives the clear.
  assign ovf_next = (clear_ovf ? '0 : overflow) | (wen & full);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      rr        <= '0;
      overflow  <= '0;
    end else begin
      overflow <= ovf_next;
      if (load_en) begin
        if (found) begin
          out_valid <= 1'b1;
          out_data  <= grant_data;
          out_lane  <= grant;
          rr        <= rr_next(grant);
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_connector_wr_merge.sv
// Directed, table-driven bench for connector_wr_merge (NLANES=3, DW=8, DEPTH=4).
module tb_connector_wr_merge;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  wen;
  logic [23:0] data;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_lane;
  logic        clear_ovf;
  logic [2:0]  overflow;
  logic [2:0]  fifo_empty;

  int passed = 0;
  int total  = 0;

  connector_wr_merge #(.NLANES(3), .DW(8), .DEPTH(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wen        (wen),
    .data       (data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .clear_ovf  (clear_ovf),
    .overflow   (overflow),
    .fifo_empty (fifo_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  wen;
    logic [23:0] data;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  el;
    logic [2:0]  eo;
    logic [2:0]  ee;
  } vec_t;

  vec_t tbl [64];
  int   n = 0;

  task automatic add(input logic [2:0] w, input logic [23:0] d, input logic r, input logic c,
                     input logic ev, input logic [7:0] ed, input logic [1:0] el,
                     input logic [2:0] eo, input logic [2:0] ee);
    tbl[n] = '{wen: w, data: d, rdy: r, clr: c, ev: ev, ed: ed, el: el, eo: eo, ee: ee};
    n++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  initial begin
    resetn    = 1'b0;
    wen       = '0;
    data      = '0;
    out_ready = 1'b1;
    clear_ovf = 1'b0;

    // Single lane: lane1 A5, then lane2 77 to bring rr back to 0
    add(3'b010, 24'h00A500, 1, 0, 0, 8'h00, 0, 3'b000, 3'b101);
    add(3'b000, 24'h000000, 1, 0, 1, 8'hA5, 1, 3'b000, 3'b111);
    add(3'b000, 24'h000000, 1, 0, 0, 8'h00, 0, 3'b000, 3'b111);
    add(3'b100, 24'h770000, 1, 0, 0, 8'h00, 0, 3'b000, 3'b011);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h77, 2, 3'b000, 3'b111);
    // Fairness from rr=0
    add(3'b111, 24'h302010, 1, 0, 0, 8'h00, 0, 3'b000, 3'b000);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h10, 0, 3'b000, 3'b001);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h20, 1, 3'b000, 3'b011);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h30, 2, 3'b000, 3'b111);
    add(3'b000, 24'h000000, 1, 0, 0, 8'h00, 0, 3'b000, 3'b111);
    // Lane1 alone leaves rr=2, then fairness from rr=2
    add(3'b010, 24'h004400, 1, 0, 0, 8'h00, 0, 3'b000, 3'b101);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h44, 1, 3'b000, 3'b111);
    add(3'b111, 24'h635241, 1, 0, 0, 8'h00, 0, 3'b000, 3'b000);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h63, 2, 3'b000, 3'b100);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h41, 0, 3'b000, 3'b101);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h52, 1, 3'b000, 3'b111);
    add(3'b000, 24'h000000, 1, 0, 0, 8'h00, 0, 3'b000, 3'b111);
    // Park a lane1 beat in the output register, stalled
    add(3'b010, 24'h00EE00, 0, 0, 0, 8'h00, 0, 3'b000, 3'b101);
    add(3'b000, 24'h000000, 0, 0, 1, 8'hEE, 1, 3'b000, 3'b111);
    // Overflow + stall: lane0 writes 0..5, writes 4 and 5 are dropped
    add(3'b001, 24'h000000, 0, 0, 1, 8'hEE, 1, 3'b000, 3'b110);
    add(3'b001, 24'h000001, 0, 0, 1, 8'hEE, 1, 3'b000, 3'b110);
    add(3'b001, 24'h000002, 0, 0, 1, 8'hEE, 1, 3'b000, 3'b110);
    add(3'b001, 24'h000003, 0, 0, 1, 8'hEE, 1, 3'b000, 3'b110);
    add(3'b001, 24'h000004, 0, 0, 1, 8'hEE, 1, 3'b001, 3'b110);
    add(3'b001, 24'h000005, 0, 0, 1, 8'hEE, 1, 3'b001, 3'b110);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h00, 0, 3'b001, 3'b110);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h01, 0, 3'b001, 3'b110);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h02, 0, 3'b001, 3'b110);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h03, 0, 3'b001, 3'b111);
    add(3'b000, 24'h000000, 1, 0, 0, 8'h00, 0, 3'b001, 3'b111);
    add(3'b000, 24'h000000, 1, 1, 0, 8'h00, 0, 3'b000, 3'b111);
    // Lane2 fill with push+pop on one edge, then overflow on the clear cycle
    add(3'b100, 24'h810000, 0, 0, 0, 8'h00, 0, 3'b000, 3'b011);
    add(3'b100, 24'h820000, 0, 0, 1, 8'h81, 2, 3'b000, 3'b011);
    add(3'b100, 24'h830000, 0, 0, 1, 8'h81, 2, 3'b000, 3'b011);
    add(3'b100, 24'h840000, 0, 0, 1, 8'h81, 2, 3'b000, 3'b011);
    add(3'b100, 24'h850000, 0, 0, 1, 8'h81, 2, 3'b000, 3'b011);
    add(3'b100, 24'h860000, 0, 1, 1, 8'h81, 2, 3'b100, 3'b011);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h82, 2, 3'b100, 3'b011);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h83, 2, 3'b100, 3'b011);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h84, 2, 3'b100, 3'b011);
    add(3'b000, 24'h000000, 1, 0, 1, 8'h85, 2, 3'b100, 3'b111);
    add(3'b000, 24'h000000, 1, 0, 0, 8'h00, 0, 3'b100, 3'b111);

    // Reset held: activity on the lanes must have no effect
    for (int i = 0; i < 3; i++) begin
      wen  = 3'($urandom);
      data = 24'($urandom);
      @(negedge clk);
      check($sformatf("rst%0d valid", i), 32'(out_valid), 0);
      check($sformatf("rst%0d ovf", i), 32'(overflow), 0);
      check($sformatf("rst%0d empty", i), 32'(fifo_empty), 32'h7);
      check($sformatf("rst%0d data", i), 32'(out_data), 0);
      check($sformatf("rst%0d lane", i), 32'(out_lane), 0);
    end
    wen    = '0;
    data   = '0;
    resetn = 1'b1;

    for (int i = 0; i < n; i++) begin
      wen       = tbl[i].wen;
      data      = tbl[i].data;
      out_ready = tbl[i].rdy;
      clear_ovf = tbl[i].clr;
      @(negedge clk);
      check($sformatf("v%0d valid", i), 32'(out_valid), 32'(tbl[i].ev));
      check($sformatf("v%0d ovf", i), 32'(overflow), 32'(tbl[i].eo));
      check($sformatf("v%0d empty", i), 32'(fifo_empty), 32'(tbl[i].ee));
      if (tbl[i].ev) begin
        check($sformatf("v%0d data", i), 32'(out_data), 32'(tbl[i].ed));
        check($sformatf("v%0d lane", i), 32'(out_lane), 32'(tbl[i].el));
      end
    end

    // Async reset mid-stream with beats queued on all lanes
    wen       = 3'b111;
    data      = 24'h030201;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    @(negedge clk);
    wen = '0;
    @(negedge clk);
    check("pre-reset valid", 32'(out_valid), 1);
    check("pre-reset data", 32'(out_data), 32'h01);
    check("pre-reset empty", 32'(fifo_empty), 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("async valid", 32'(out_valid), 0);
    check("async empty", 32'(fifo_empty), 32'h7);
    check("async ovf", 32'(overflow), 0);
    @(negedge clk);
    resetn    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post-reset%0d valid", i), 32'(out_valid), 0);
      check($sformatf("post-reset%0d empty", i), 32'(fifo_empty), 32'h7);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
